// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered N-input selector with a valid/ready output handshake.
// A main (head) register plus a skid register let the stage accept one entry
// per cycle while in_ready depends only on the occupancy state register.
module mux_pipe_n #(
    parameter int               WIDTH   = 32,
    parameter int               NUM_IN  = 4,
    parameter int               SEL_W   = 2,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        dout,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             load_main_in, load_skid_in, load_main_skid;

    logic [WIDTH-1:0] main_data_q, skid_data_q;
    logic [SEL_W-1:0] main_sel_q,  skid_sel_q;
    logic             main_err_q,  skid_err_q;

    // An entry is taken only when the stage has room and no flush discards it.
    assign accept = in_valid && in_ready && !flush;

    // Build the entry to capture: selected input, or DEFAULT for an out-of-range index.
    always_comb begin
        cap_err  = (32'(sel) >= 32'(NUM_IN));
        cap_data = DEFAULT;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy state register; reset dominates flush, which the next-state logic handles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy from accept/drain; flush empties the stage regardless of traffic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) state_d = S_ONE;
                S_ONE: begin
                    if (accept && !out_ready)      state_d = S_TWO;
                    else if (!accept && out_ready) state_d = S_EMPTY;
                end
                S_TWO:   if (out_ready) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Handshake outputs and register load enables, all derived from the state register.
    always_comb begin
        in_ready       = (state_q != S_TWO);
        out_valid      = (state_q != S_EMPTY);
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (!flush) begin
            case (state_q)
                S_EMPTY: load_main_in = accept;
                S_ONE: begin
                    load_main_in = accept && out_ready;
                    load_skid_in = accept && !out_ready;
                end
                S_TWO:   load_main_skid = out_ready;
                default: ;
            endcase
        end
    end

    // Head and skid storage; the head only changes on an accept into an empty/draining
    // stage or when the skid entry advances, so it is stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data_q <= cap_data;
                main_sel_q  <= sel;
                main_err_q  <= cap_err;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_sel_q  <= skid_sel_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid_in) begin
                skid_data_q <= cap_data;
                skid_sel_q  <= sel;
                skid_err_q  <= cap_err;
            end
        end
    end

    assign dout    = main_data_q;
    assign out_sel = main_sel_q;
    assign sel_err = main_err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Testbench for mux_pipe_n: two instances (4-input and 5-input with DEFAULT)
// share control stimulus; expected entries are queued at issue time and a
// monitor pops and compares them on each downstream transfer.
module tb_mux_pipe_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, in_valid, out_ready;
    logic [2:0]   sel;
    logic [159:0] din5;
    logic [127:0] din4;
    assign din4 = din5[127:0];

    logic        ra, va, rb, vb;
    logic [31:0] da, db;
    logic [1:0]  sa;
    logic [2:0]  sb;
    logic        ea, eb;

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT(32'h0)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ra),
        .sel(sel[1:0]), .din(din4), .out_valid(va), .out_ready(out_ready),
        .dout(da), .out_sel(sa), .sel_err(ea)
    );

    mux_pipe_n #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .DEFAULT(32'hDEADBEEF)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rb),
        .sel(sel), .din(din5), .out_valid(vb), .out_ready(out_ready),
        .dout(db), .out_sel(sb), .sel_err(eb)
    );

    typedef struct {
        logic [31:0] d;
        logic [2:0]  s;
        logic        e;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t xa, xb;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench model of the input table, used by the randomized run.
    function automatic logic [31:0] tbl(input int k);
        case (k)
            0:       return 32'h00000000;
            1:       return 32'h11111111;
            2:       return 32'h22222222;
            3:       return 32'h33333333;
            4:       return 32'h44444444;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Monitor: a transfer happens at the next rising edge when out_valid && out_ready.
    always @(negedge clk) begin
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (va && out_ready) begin
                if (qa.size() == 0) chk("a_extra_output", 1, 0);
                else begin
                    xa = qa.pop_front();
                    chk("a_dout", da, xa.d);
                    chk("a_out_sel", sa, xa.s[1:0]);
                    chk("a_sel_err", ea, xa.e);
                end
            end
            if (vb && out_ready) begin
                if (qb.size() == 0) chk("b_extra_output", 1, 0);
                else begin
                    xb = qb.pop_front();
                    chk("b_dout", db, xb.d);
                    chk("b_out_sel", sb, xb.s);
                    chk("b_sel_err", eb, xb.e);
                end
            end
            if (flush) begin
                qa.delete();
                qb.delete();
            end
        end
    end

    // Drive one cycle; queue expected entries for whichever instances accept.
    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] exa,
                         input logic [31:0] exb, input logic exbe);
        exp_t t;
        in_valid = v;
        sel      = s;
        if (v && !reset && !flush) begin
            if (ra) begin
                t.d = exa; t.s = {1'b0, s[1:0]}; t.e = 1'b0;
                qa.push_back(t);
            end
            if (rb) begin
                t.d = exb; t.s = s; t.e = exbe;
                qb.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {va, vb}, 2'b00);
        chk({tag, "_in_ready"},  {ra, rb}, 2'b11);
        chk({tag, "_dout_a"},    da, 32'h0);
        chk({tag, "_dout_b"},    db, 32'h0);
        chk({tag, "_out_sel"},   {sa, sb}, 5'b0);
        chk({tag, "_sel_err"},   {ea, eb}, 2'b00);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 3'd0;
        din5 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        idle();

        // Single transfer, sel=2
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 32'h22222222, 32'h22222222, 1'b0);
        chk("t1_valid", {va, vb}, 2'b11);
        chk("t1_dout", da, 32'h22222222);
        chk("t1_out_sel", sa, 2'd2);
        idle();
        chk("t1_valid_drop", {va, vb}, 2'b00);

        // Streaming 0..3
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), tbl(i), tbl(i), 1'b0);
            chk("stream_dout", da, tbl(i));
            chk("stream_in_ready", {ra, rb}, 2'b11);
        end
        idle();
        idle();

        // Backpressure: sel=1 then sel=3 with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h11111111, 32'h11111111, 1'b0);
        chk("bp_ready_one", {ra, rb}, 2'b11);
        drive(1'b1, 3'd3, 32'h33333333, 32'h33333333, 1'b0);
        chk("bp_ready_two", {ra, rb}, 2'b00);
        chk("bp_hold1", da, 32'h11111111);
        idle();
        chk("bp_hold2", da, 32'h11111111);
        out_ready = 1'b1;
        idle();
        chk("bp_drain1_dout", da, 32'h33333333);
        chk("bp_drain1_ready", {ra, rb}, 2'b11);
        idle();
        chk("bp_empty", {va, vb}, 2'b00);

        // Out-of-range select on the 5-input instance
        drive(1'b1, 3'd7, 32'h33333333, 32'hDEADBEEF, 1'b1);
        chk("oor_dout", db, 32'hDEADBEEF);
        chk("oor_sel", sb, 3'd7);
        chk("oor_err", eb, 1'b1);
        drive(1'b1, 3'd4, 32'h00000000, 32'h44444444, 1'b0);
        chk("in4_dout", db, 32'h44444444);
        chk("in4_err", eb, 1'b0);
        idle();

        // Flush while full, with a same-cycle input and out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h11111111, 32'h11111111, 1'b0);
        drive(1'b1, 3'd2, 32'h22222222, 32'h22222222, 1'b0);
        flush = 1'b1;
        drive(1'b1, 3'd3, 32'h33333333, 32'h33333333, 1'b0);
        flush = 1'b0;
        chk("flush_valid", {va, vb}, 2'b00);
        chk("flush_ready", {ra, rb}, 2'b11);
        out_ready = 1'b1;
        idle();
        idle();
        drive(1'b1, 3'd2, 32'h22222222, 32'h22222222, 1'b0);
        chk("flush_next_head", da, 32'h22222222);
        idle();

        // Same sequence with reset instead of flush
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h11111111, 32'h11111111, 1'b0);
        drive(1'b1, 3'd3, 32'h33333333, 32'h33333333, 1'b0);
        reset = 1'b1;
        drive(1'b1, 3'd2, 32'h22222222, 32'h22222222, 1'b0);
        reset = 1'b0;
        chk_reset_vals("rst_mid");
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 32'h11111111, 32'h11111111, 1'b0);
        chk("rst_next_head", da, 32'h11111111);
        idle();

        // Reset together with flush, in_valid and out_ready
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 32'h22222222, 32'h22222222, 1'b0);
        drive(1'b1, 3'd3, 32'h33333333, 32'h33333333, 1'b0);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 3'd1, 32'h11111111, 32'h11111111, 1'b0);
        reset = 1'b0; flush = 1'b0;
        chk_reset_vals("rst_all");

        // Randomized stall/flush traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            logic [2:0] s;
            logic       v;
            s         = 3'($urandom_range(0, 7));
            v         = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            drive(v, s, tbl(int'(s[1:0])), tbl(int'(s)), (s >= 3'd5));
        end
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) idle();
        chk("a_leftover", qa.size(), 0);
        chk("b_leftover", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised N-input, registered selection stage for the MIPS32 datapath. It picks one of NUM_IN WIDTH-bit inputs by index, registers the result, and presents it downstream through a valid/ready handshake. A two-entry skid buffer sustains one transfer per cycle with no combinational path from out_ready to in_ready. It replaces fixed 4:1 combinational selectors wherever the selected operand must cross a pipeline boundary with stall and flush support.

## Interface
- WIDTH, 32, data width of each input and of dout
- NUM_IN, 4, number of selectable inputs, 2..16
- SEL_W, 2, select width, must equal ceil(log2(NUM_IN))
- DEFAULT, 0, WIDTH-bit value substituted when sel >= NUM_IN
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  upstream presents sel/din
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready
- sel  input  SEL_W  input index
- din  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  1  dout/out_sel/sel_err hold a valid entry
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready
- dout  output  WIDTH  selected data of head entry
- out_sel  output  SEL_W  select index captured with head entry
- sel_err  output  1  head entry was captured with sel >= NUM_IN

## Operation
- On accept: capture {din[sel], sel, 0}, or {DEFAULT, sel, 1} when sel >= NUM_IN.
- Storage: main register (head, drives outputs) plus skid register.
- State machine over occupancy:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE, loads main.
  - ONE: out_valid=1, in_ready=1.
    - Accept && out_ready -> ONE, main reloads.
    - Accept && !out_ready -> TWO, loads skid.
    - No accept && out_ready -> EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0. out_ready -> ONE, skid moves to main. Otherwise hold.
- in_ready = (state != TWO); it is a function of the state register only.
- Head outputs are stable while out_valid && !out_ready. Entries leave in acceptance order, with no loss or duplication.
- flush: next state EMPTY. Any accept in the same cycle is dropped. Any out_ready in the same cycle still counts as a downstream transfer of the current head.
- Priority: reset > flush > normal operation.
- Reset values: state EMPTY, out_valid 0, in_ready 1, dout 0, out_sel 0, sel_err 0. Skid contents are cleared to 0.
- Reset or flush mid-transfer: no entry survives, and the first accept afterwards is the next head.

## Timing
- Latency: an accept at edge n gives out_valid=1 with that data after edge n, at zero wait states.
- Throughput: 1 entry/cycle while out_ready stays high.
- A single out_ready low cycle is absorbed by the skid. in_ready falls only after the second accept without drain.
- No combinational path from out_ready or in_valid to in_ready or out_valid.
- dout, out_sel and sel_err are register outputs.

## Test plan
- Reset, then NUM_IN=4, WIDTH=32, din={D3=0x33333333, D2=0x22222222, D1=0x11111111, D0=0x00000000}, sel=2, one-cycle in_valid, out_ready=1.
  -> Next cycle: out_valid=1, dout=0x22222222, out_sel=2, sel_err=0. One cycle later out_valid=0.
- Streaming: sel=0,1,2,3 on consecutive cycles with out_ready=1.
  -> dout 0x0, 0x11111111, 0x22222222, 0x33333333 on four consecutive cycles; in_ready constantly 1.
- Backpressure: out_ready=0 while accepting sel=1 then sel=3.
  -> in_ready drops to 0 after the second accept; dout holds 0x11111111.
  -> Raise out_ready: 0x11111111 then 0x33333333 delivered; in_ready returns to 1 after the first drain.
- NUM_IN=5, SEL_W=3, DEFAULT=0xDEADBEEF, sel=7.
  -> dout=0xDEADBEEF, out_sel=7, sel_err=1.
  -> Then sel=4 gives din input 4, sel_err=0.
- Flush in TWO with in_valid=1 and out_ready=0.
  -> Next cycle out_valid=0, in_ready=1; the flushed and the same-cycle inputs never appear.
  -> Same sequence with reset instead of flush gives identical result plus dout=0.
- Reset asserted together with flush, in_valid and out_ready.
  -> All outputs equal reset values on the next cycle.
  -> A randomized stall/flush run checked against a FIFO scoreboard shows no ordering errors.
